mult_seq_n: RTL and testbench
=============================

# mult_seq_n

Parametrised sequential shift-add multiplier: the WIDTH-generic successor to the 8-bit switch-driven multiplier. Multiplicand S comes from Din at start. Multiplier B is pre-loaded from Din. The 2·WIDTH-bit product is left in A:B with sign/carry bit X. It supports continuous multiplication (a new Run multiplies the low product half by a new S) and sits between the switch/button front end and the hex display drivers.

## Interface
- WIDTH, 8, operand width in bits (≥2)
- Clk  in  1  system clock; all state changes on rising edge
- Reset  in  1  asynchronous, active-high reset
- ClearA_LoadB  in  1  synchronous; in IDLE: B←Din, A←0, X←0
- Run  in  1  level; rising edge seen in IDLE starts a multiply
- Din  in  WIDTH  operand input (switches)
- Aval  out  WIDTH  register A (product upper half)
- Bval  out  WIDTH  register B (product lower half)
- X  out  1  sign-extension bit (signed build) / carry bit (unsigned build)
- Busy  out  1  high from CLRA through last SHIFT
- Done  out  1  high in HOLD

## Operation
- States: IDLE, CLRA, ADD, SHIFT, HOLD. Bit counter i runs 0..WIDTH-1.
- IDLE:
  - ClearA_LoadB=1 → B←Din, A←0, X←0.
  - Run=1 with registered Run_prev=0 → CLRA. Run takes priority over ClearA_LoadB in the same cycle.
- CLRA: A←0, X←0, S←Din, i←0 → ADD.
- ADD:
  - If B[0]=1, {X,A} ← ext(A) + ext(S) for i<WIDTH-1.
  - If B[0]=1 and i=WIDTH-1, {X,A} ← ext(A) − ext(S). This subtract step is signed build only; the unsigned build adds.
  - ext = sign-extend by 1 (signed) or zero-extend (unsigned). Result is WIDTH+1 bits, no overflow possible.
  - If B[0]=0: A and X unchanged.
  - → SHIFT.
- SHIFT: {X,A,B} ← right shift by 1.
  - Signed: X kept (arithmetic shift). Unsigned: X←0.
  - If i=WIDTH-1 → HOLD, else i←i+1 → ADD.
- HOLD: Done=1. Stay while Run=1; Run=0 → IDLE. A and B are held.
- Continuous mode: a new Run without ClearA_LoadB uses the current B (low product half) as the multiplier.
- Run edges and ClearA_LoadB outside IDLE are ignored.
- Din changes after CLRA have no effect.

## Timing
- Reset (async, any state): state=IDLE, A=0, B=0, S=0, X=0, i=0, Busy=0, Done=0, Run_prev=0. Reset mid-multiply aborts with no partial result retained.
- Edge k samples a Run rising edge in IDLE. Then:
  - CLRA is at edge k+1.
  - ADD/SHIFT pairs occupy edges k+2 .. k+1+2·WIDTH.
  - Done rises after edge k+1+2·WIDTH. Latency = 2·WIDTH+1 cycles (17 for WIDTH=8).
- Busy=1 for exactly 2·WIDTH+1 cycles.
- Run held high through completion is not a new edge; re-start requires Run low ≥1 cycle.
- Run released before completion: the multiply still finishes; HOLD exits to IDLE on the next edge.
- Outputs are registered: no combinational path from inputs to outputs.

## Configuration
- MULT_SIGNED_EN defined: two's-complement operands, final-step subtract, arithmetic shift, X = sign.
- Not defined: unsigned operands, every step adds, X = carry and shifts in as 0.
- Product is {A,B} in both builds. {X,A,B} is not a valid result until Done.

## Test plan
- Signed, WIDTH=8: ClearA_LoadB with Din=8'hC5 (−59), Run with Din=8'h07 → Done after 17 cycles, {A,B}=16'hFE63 (−413), X=1.
- Signed: B=8'h3B, S=8'hF9 → 16'hFE63. B=8'h3B, S=8'h07 → 16'h019D. B=8'hC5, S=8'hF9 → 16'h019D. B=8'h74, S=8'h74 → 16'h3490.
- Continuous: after the 7×59 case (B=8'h9D), Run with Din=8'h02 and no clear → {A,B}=16'hFF3A (2×−99).
- Handshake: hold Run high 40 cycles → exactly one multiply. Busy=1 for 17 cycles. Done stays high until Run=0, then IDLE. ClearA_LoadB pulsed while Busy → no effect.
- Reset mid-op: assert Reset at cycle 6 of a multiply → all outputs 0 immediately, IDLE. A subsequent multiply is correct.
- WIDTH=16 signed: 16'h8000 × 16'h8000 → 32'h40000000. Unsigned build, WIDTH=8: 8'hFF × 8'hFF → 16'hFE01, X=0.

Source files
------------

// File: rtl/mult_seq_n.sv
// Sequential shift-add multiplier, WIDTH-generic: {A,B} <= B * S over 2*WIDTH+1 cycles.
// Define MULT_SIGNED_EN for two's-complement operands; the default build is unsigned.
module mult_seq_n #(
  parameter int WIDTH = 8
) (
  input  logic             Clk,
  input  logic             Reset,
  input  logic             ClearA_LoadB,
  input  logic             Run,
  input  logic [WIDTH-1:0] Din,
  output logic [WIDTH-1:0] Aval,
  output logic [WIDTH-1:0] Bval,
  output logic             X,
  output logic             Busy,
  output logic             Done
);

  localparam int IW = (WIDTH > 2) ? $clog2(WIDTH) : 1;
  localparam logic [IW-1:0] I_LAST = IW'(WIDTH - 1);

  typedef enum logic [2:0] {IDLE, CLRA, ADD, SHIFT, HOLD} state_t;

  state_t           state_reg, state_next;
  logic [WIDTH-1:0] a_reg, a_next;
  logic [WIDTH-1:0] b_reg, b_next;
  logic [WIDTH-1:0] s_reg, s_next;
  logic             x_reg, x_next;
  logic [IW-1:0]    i_reg, i_next;
  logic             run_prev_reg;
  logic             busy_reg, busy_next;
  logic             done_reg, done_next;

  logic [WIDTH:0]   a_ext, s_ext, addsub;
  logic             last_step;

  assign last_step = (i_reg == I_LAST);

  // One-bit extension makes the WIDTH+1-bit sum overflow-free.
  always_comb begin
`ifdef MULT_SIGNED_EN
    a_ext  = {a_reg[WIDTH-1], a_reg};
    s_ext  = {s_reg[WIDTH-1], s_reg};
    // The multiplier's MSB carries negative weight, so its partial product is subtracted.
    addsub = last_step ? (a_ext - s_ext) : (a_ext + s_ext);
`else
    a_ext  = {1'b0, a_reg};
    s_ext  = {1'b0, s_reg};
    addsub = a_ext + s_ext;
`endif
  end

  always_comb begin
    state_next = state_reg;
    a_next     = a_reg;
    b_next     = b_reg;
    s_next     = s_reg;
    x_next     = x_reg;
    i_next     = i_reg;
    case (state_reg)
      IDLE: begin
        if (Run && !run_prev_reg) begin
          state_next = CLRA;
        end else if (ClearA_LoadB) begin
          b_next = Din;
          a_next = '0;
          x_next = 1'b0;
        end
      end
      CLRA: begin
        a_next     = '0;
        x_next     = 1'b0;
        s_next     = Din;
        i_next     = '0;
        state_next = ADD;
      end
      ADD: begin
        if (b_reg[0]) begin
          {x_next, a_next} = addsub;
        end
        state_next = SHIFT;
      end
      SHIFT: begin
`ifdef MULT_SIGNED_EN
        {x_next, a_next, b_next} = {x_reg, x_reg, a_reg, b_reg[WIDTH-1:1]};
`else
        {x_next, a_next, b_next} = {1'b0, x_reg, a_reg, b_reg[WIDTH-1:1]};
`endif
        if (last_step) begin
          state_next = HOLD;
        end else begin
          i_next     = i_reg + IW'(1);
          state_next = ADD;
        end
      end
      HOLD: begin
        if (!Run) state_next = IDLE;
      end
      default: state_next = IDLE;
    endcase
    busy_next = (state_next == CLRA) || (state_next == ADD) || (state_next == SHIFT);
    done_next = (state_next == HOLD);
  end

  always_ff @(posedge Clk or posedge Reset) begin
    if (Reset) begin
      state_reg    <= IDLE;
      a_reg        <= '0;
      b_reg        <= '0;
      s_reg        <= '0;
      x_reg        <= 1'b0;
      i_reg        <= '0;
      run_prev_reg <= 1'b0;
      busy_reg     <= 1'b0;
      done_reg     <= 1'b0;
    end else begin
      state_reg    <= state_next;
      a_reg        <= a_next;
      b_reg        <= b_next;
      s_reg        <= s_next;
      x_reg        <= x_next;
      i_reg        <= i_next;
      run_prev_reg <= Run;
      busy_reg     <= busy_next;
      done_reg     <= done_next;
    end
  end

  assign Aval = a_reg;
  assign Bval = b_reg;
  assign X    = x_reg;
  assign Busy = busy_reg;
  assign Done = done_reg;

endmodule

// File: tb/tb_mult_seq_n.sv
// Directed bench for mult_seq_n; expected products follow MULT_SIGNED_EN when it is defined.
module tb_mult_seq_n;

  localparam int W = 8;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic           rst, clr_ld, run;
  logic [W-1:0]   din, aval, bval;
  logic           x, busy, done;

  logic           clr16, run16;
  logic [15:0]    din16, aval16, bval16;
  logic           x16, busy16, done16;

  mult_seq_n #(.WIDTH(W)) u_dut (
    .Clk(clk), .Reset(rst), .ClearA_LoadB(clr_ld), .Run(run), .Din(din),
    .Aval(aval), .Bval(bval), .X(x), .Busy(busy), .Done(done)
  );

  mult_seq_n #(.WIDTH(16)) u_dut16 (
    .Clk(clk), .Reset(rst), .ClearA_LoadB(clr16), .Run(run16), .Din(din16),
    .Aval(aval16), .Bval(bval16), .X(x16), .Busy(busy16), .Done(done16)
  );

  typedef struct {
    logic [W-1:0]   b;
    logic [W-1:0]   s;
    logic [2*W-1:0] p;
    logic           xp;
  } vec_t;

  vec_t vecs[7];
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end else begin
      $display("[TB] ok   %s = %0h", name, act);
    end
  endtask

  task automatic load_b(input logic [W-1:0] b);
    @(negedge clk);
    clr_ld = 1'b1;
    din    = b;
    @(negedge clk);
    clr_ld = 1'b0;
  endtask

  // lat = edges after the Run-sampling edge until Done; bcnt = cycles with Busy high.
  task automatic start_mult(input logic [W-1:0] s, output int lat, output int bcnt);
    @(negedge clk);
    din  = s;
    run  = 1'b1;
    lat  = -1;
    bcnt = 0;
    for (int n = 0; n < 100; n++) begin
      @(posedge clk);
      #1;
      if (n == 2) din = ~s;
      if (busy) bcnt++;
      if (done) begin
        lat = n;
        break;
      end
    end
  endtask

  task automatic end_mult(input string tag);
    @(negedge clk);
    run = 1'b0;
    @(posedge clk);
    #1;
    chk({tag, "_done_low"}, {63'd0, done}, 64'd0);
  endtask

  int lat, bcnt, rises, hold_busy;
  logic busy_q;
  logic [2*W-1:0] p_cont, p_hs;
  logic           x_cont;

  initial begin
`ifdef MULT_SIGNED_EN
    vecs[0] = '{8'hC5, 8'h07, 16'hFE63, 1'b1};
    vecs[1] = '{8'h3B, 8'hF9, 16'hFE63, 1'b1};
    vecs[2] = '{8'h3B, 8'h07, 16'h019D, 1'b0};
    vecs[3] = '{8'hC5, 8'hF9, 16'h019D, 1'b0};
    vecs[4] = '{8'h74, 8'h74, 16'h3490, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 16'h0001, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 16'h4000, 1'b0};
    p_cont = 16'hFF3A; x_cont = 1'b1;
`else
    vecs[0] = '{8'hC5, 8'h07, 16'h0563, 1'b0};
    vecs[1] = '{8'h3B, 8'hF9, 16'h3963, 1'b0};
    vecs[2] = '{8'h3B, 8'h07, 16'h019D, 1'b0};
    vecs[3] = '{8'hC5, 8'hF9, 16'hBF9D, 1'b0};
    vecs[4] = '{8'h74, 8'h74, 16'h3490, 1'b0};
    vecs[5] = '{8'hFF, 8'hFF, 16'hFE01, 1'b0};
    vecs[6] = '{8'h80, 8'h80, 16'h4000, 1'b0};
    p_cont = 16'h013A; x_cont = 1'b0;
`endif
    p_hs = 16'h019D;

    rst = 1'b1; clr_ld = 1'b0; run = 1'b0; din = '0;
    clr16 = 1'b0; run16 = 1'b0; din16 = '0;
    repeat (2) @(posedge clk);
    #1;
    chk("reset_ab", {32'd0, aval, bval, 8'd0, x, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0;

    foreach (vecs[i]) begin
      load_b(vecs[i].b);
      start_mult(vecs[i].s, lat, bcnt);
      chk($sformatf("v%0d_product", i), {48'd0, aval, bval}, {48'd0, vecs[i].p});
      chk($sformatf("v%0d_x", i), {63'd0, x}, {63'd0, vecs[i].xp});
      if (i == 0) begin
        chk("latency", 64'(lat), 64'd17);
        chk("busy_cycles", 64'(bcnt), 64'd17);
      end
      end_mult($sformatf("v%0d", i));
    end

    // Run held 40 cycles with a stray ClearA_LoadB while busy.
    load_b(8'h3B);
    @(negedge clk);
    din = 8'h07; run = 1'b1;
    rises = 0; hold_busy = 0; busy_q = 1'b0;
    for (int c = 0; c < 40; c++) begin
      @(posedge clk);
      #1;
      if (c == 5) begin clr_ld = 1'b1; din = 8'h55; end
      if (c == 6) clr_ld = 1'b0;
      if (busy) hold_busy++;
      if (busy && !busy_q) rises++;
      busy_q = busy;
    end
    chk("hold_one_start", 64'(rises), 64'd1);
    chk("hold_busy_cycles", 64'(hold_busy), 64'd17);
    chk("hold_done_high", {63'd0, done}, 64'd1);
    chk("hold_product", {48'd0, aval, bval}, {48'd0, p_hs});
    end_mult("hold");
    chk("idle_keeps_product", {48'd0, aval, bval}, {48'd0, p_hs});

    // Continuous: B now holds the low half 8'h9D.
    start_mult(8'h02, lat, bcnt);
    chk("cont_product", {48'd0, aval, bval}, {48'd0, p_cont});
    chk("cont_x", {63'd0, x}, {63'd0, x_cont});
    end_mult("cont");

    // Asynchronous reset six cycles into a multiply.
    load_b(8'hC5);
    @(negedge clk);
    din = 8'h07; run = 1'b1;
    repeat (6) @(posedge clk);
    #1;
    rst = 1'b1;
    #1;
    chk("midreset_outputs", {32'd0, aval, bval, 8'd0, x, busy, done}, 64'd0);
    @(negedge clk);
    rst = 1'b0; run = 1'b0;
    load_b(8'hC5);
    start_mult(8'h07, lat, bcnt);
    chk("after_reset_product", {48'd0, aval, bval}, {48'd0, vecs[0].p});
    chk("after_reset_latency", 64'(lat), 64'd17);
    end_mult("after_reset");

    // WIDTH=16 corner: 0x8000 * 0x8000 is 0x40000000 in both builds.
    @(negedge clk);
    clr16 = 1'b1; din16 = 16'h8000;
    @(negedge clk);
    clr16 = 1'b0; run16 = 1'b1;
    lat = -1;
    for (int n = 0; n < 200; n++) begin
      @(posedge clk);
      #1;
      if (done16) begin
        lat = n;
        break;
      end
    end
    chk("w16_latency", 64'(lat), 64'd33);
    chk("w16_product", {32'd0, aval16, bval16}, 64'h40000000);
    chk("w16_x", {63'd0, x16}, 64'd0);
    @(negedge clk);
    run16 = 1'b0;
    @(negedge clk);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
